// File: rtl/i2s_transmitter.sv
// I2S master transmitter: serialises parallel left/right samples MSB-first with generated SCK/WS.
// Define I2S_TX_LEFT_JUSTIFIED_EN for left-justified WS timing; default is standard I2S (one-bit delay).
module i2s_transmitter #(
  parameter int DATA_W   = 16,
  parameter int HALF_DIV = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_left,
  input  logic [DATA_W-1:0] i_right,
  output logic              o_ready,
  output logic              o_sck,
  output logic              o_ws,
  output logic              o_sd,
  output logic              o_frame_start,
  output logic              o_underrun
);

  localparam int FRAME_BITS = 2 * DATA_W;
  localparam int DIV_W      = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;
  localparam int P_W        = $clog2(FRAME_BITS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_DIV - 1);
  localparam logic [P_W-1:0]   P_LAST   = P_W'(FRAME_BITS - 1);

  logic [DIV_W-1:0]      div_cnt;
  logic [P_W-1:0]        p_cnt;
  logic [FRAME_BITS-1:0] shift_q;
  logic [FRAME_BITS-1:0] last_q;
  logic [FRAME_BITS-1:0] buf_q;
  logic                  buf_full;

  logic                  div_tc;
  logic                  fall;
  logic                  frame_start;
  logic                  xfer;
  logic [P_W-1:0]        p_next;
  logic                  ws_next;
  logic [FRAME_BITS-1:0] in_pair;
  logic [FRAME_BITS-1:0] load_pair;

  assign o_ready     = ~buf_full & ~i_reset;
  assign xfer        = i_valid & o_ready;
  assign in_pair     = {i_left, i_right};
  assign div_tc      = (div_cnt == DIV_LAST);
  assign fall        = div_tc & o_sck;
  assign frame_start = fall & (p_cnt == P_LAST);
  assign p_next      = (p_cnt == P_LAST) ? '0 : p_cnt + 1'b1;

  // Buffered pair wins, then a same-cycle bypass, else repeat the last pair.
  assign load_pair = buf_full ? buf_q : (xfer ? in_pair : last_q);

`ifdef I2S_TX_LEFT_JUSTIFIED_EN
  assign ws_next = (p_next >= P_W'(DATA_W));
`else
  assign ws_next = (p_next >= P_W'(DATA_W - 1)) && (p_next <= P_W'(FRAME_BITS - 2));
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      div_cnt       <= '0;
      p_cnt         <= P_LAST;
      shift_q       <= '0;
      last_q        <= '0;
      buf_q         <= '0;
      buf_full      <= 1'b0;
      o_sck         <= 1'b0;
      o_ws          <= 1'b0;
      o_sd          <= 1'b0;
      o_frame_start <= 1'b0;
      o_underrun    <= 1'b0;
    end else begin
      o_frame_start <= 1'b0;
      o_underrun    <= 1'b0;

      if (div_tc) begin
        div_cnt <= '0;
        o_sck   <= ~o_sck;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end

      if (fall) begin
        p_cnt <= p_next;
        o_ws  <= ws_next;
        if (frame_start) begin
          o_sd          <= load_pair[FRAME_BITS-1];
          shift_q       <= {load_pair[FRAME_BITS-2:0], 1'b0};
          last_q        <= load_pair;
          o_frame_start <= 1'b1;
          o_underrun    <= ~buf_full & ~xfer;
        end else begin
          o_sd    <= shift_q[FRAME_BITS-1];
          shift_q <= {shift_q[FRAME_BITS-2:0], 1'b0};
        end
      end

      // A transfer landing on a frame start with the buffer empty bypasses it.
      if (frame_start && buf_full) begin
        buf_full <= 1'b0;
      end else if (xfer && !frame_start) begin
        buf_full <= 1'b1;
        buf_q    <= in_pair;
      end
    end
  end

endmodule

// File: tb/tb_i2s_transmitter.sv
// Directed bench for i2s_transmitter: table of frames plus hand-written corner sequences.
module tb_i2s_transmitter;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_valid;
  logic [15:0] i_left;
  logic [15:0] i_right;
  logic        o_ready;
  logic        o_sck;
  logic        o_ws;
  logic        o_sd;
  logic        o_frame_start;
  logic        o_underrun;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  i2s_transmitter #(.DATA_W(16), .HALF_DIV(4)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_valid(i_valid),
    .i_left(i_left), .i_right(i_right), .o_ready(o_ready),
    .o_sck(o_sck), .o_ws(o_ws), .o_sd(o_sd),
    .o_frame_start(o_frame_start), .o_underrun(o_underrun)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc++;

  typedef struct {
    logic        offer;
    logic [15:0] l;
    logic [15:0] r;
    logic [15:0] el;
    logic [15:0] er;
    logic        eu;
  } vec_t;

  vec_t vecs[6];

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  function automatic logic exp_ws(input int p);
`ifdef I2S_TX_LEFT_JUSTIFIED_EN
    return (p >= 16);
`else
    return (p >= 15) && (p <= 30);
`endif
  endfunction

  task automatic wait_fs();
    int n = 0;
    while (!o_frame_start && n < 600) begin
      @(negedge i_clk);
      n++;
    end
    if (!o_frame_start) chk("frame_start_timeout", 32'(n), 32'd0);
  endtask

  task automatic offer(input logic [15:0] l, input logic [15:0] r);
    int n = 0;
    i_left  = l;
    i_right = r;
    i_valid = 1'b1;
    #1;
    while (!o_ready && n < 600) begin
      @(negedge i_clk);
      n++;
    end
    if (!o_ready) chk("offer_timeout", 32'(n), 32'd0);
    @(posedge i_clk);
    @(negedge i_clk);
    i_valid = 1'b0;
  endtask

  // Decode one frame from the frame-start negedge, sampling SD/WS on rising SCK.
  task automatic capture(input string name, input logic [15:0] el, input logic [15:0] er);
    logic        prev;
    logic [31:0] bits;
    int k = 0;
    int n = 0;
    int ws_err = 0;
    prev = o_sck;
    bits = '0;
    while (k < 32 && n < 400) begin
      @(negedge i_clk);
      n++;
      if (o_sck && !prev) begin
        bits[31-k] = o_sd;
        if (o_ws !== exp_ws(k)) ws_err++;
        k++;
      end
      prev = o_sck;
    end
    chk({name, "_bits"}, 32'(k), 32'd32);
    chk({name, "_ws"}, 32'(ws_err), 32'd0);
    chk({name, "_left"}, {16'h0, bits[31:16]}, {16'h0, el});
    chk({name, "_right"}, {16'h0, bits[15:0]}, {16'h0, er});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int c0;
    int len, ws_h, sck_h, und, sd_ones, rises;
    logic prev;
    logic [15:0] abc_l [3];
    logic [15:0] abc_r [3];

    vecs[0] = '{1'b1, 16'hA5C3, 16'h1234, 16'hA5C3, 16'h1234, 1'b0};
    vecs[1] = '{1'b0, 16'h0000, 16'h0000, 16'hA5C3, 16'h1234, 1'b1};
    vecs[2] = '{1'b1, 16'h8001, 16'h7FFE, 16'h8001, 16'h7FFE, 1'b0};
    vecs[3] = '{1'b1, 16'hFFFF, 16'h0000, 16'hFFFF, 16'h0000, 1'b0};
    vecs[4] = '{1'b1, 16'h0000, 16'hFFFF, 16'h0000, 16'hFFFF, 1'b0};
    vecs[5] = '{1'b0, 16'h5555, 16'hAAAA, 16'h0000, 16'hFFFF, 1'b1};
    abc_l = '{16'h1111, 16'h2222, 16'h3333};
    abc_r = '{16'hAAAA, 16'hBBBB, 16'hCCCC};

    i_reset = 1'b1;
    i_valid = 1'b0;
    i_left  = '0;
    i_right = '0;
    repeat (3) @(negedge i_clk);
    chk("reset_outputs", {27'h0, o_sck, o_ws, o_sd, o_frame_start, o_underrun}, 32'h0);
    chk("reset_ready", {31'h0, o_ready}, 32'h0);

    // Idle frame after reset: zeros, one underrun, 8-cycle SCK, 128-cycle WS high.
    i_reset = 1'b0;
    c0 = cyc;
    wait_fs();
    chk("idle_first_fs_delay", 32'(cyc - c0), 32'd8);
    len = 0; ws_h = 0; sck_h = 0; und = 0; sd_ones = 0; rises = 0;
    prev = o_sck;
    do begin
      ws_h += o_ws; sck_h += o_sck; und += o_underrun; sd_ones += o_sd;
      if (o_sck && !prev) rises++;
      prev = o_sck;
      len++;
      @(negedge i_clk);
    end while (!o_frame_start && len < 400);
    chk("idle_frame_len", 32'(len), 32'd256);
    chk("idle_ws_high", 32'(ws_h), 32'd128);
    chk("idle_sck_high", 32'(sck_h), 32'd128);
    chk("idle_sck_rises", 32'(rises), 32'd32);
    chk("idle_underruns", 32'(und), 32'd1);
    chk("idle_sd_ones", 32'(sd_ones), 32'd0);
    chk("idle_next_underrun", {31'h0, o_underrun}, 32'h1);

    // Table-driven frames after a fresh reset.
    i_reset = 1'b1;
    repeat (2) @(negedge i_clk);
    i_reset = 1'b0;
    c0 = cyc;
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].offer) offer(vecs[i].l, vecs[i].r);
      wait_fs();
      if (i == 0) chk("first_fs_delay", 32'(cyc - c0), 32'd8);
      chk($sformatf("vec%0d_underrun", i), {31'h0, o_underrun}, {31'h0, vecs[i].eu});
      capture($sformatf("vec%0d", i), vecs[i].el, vecs[i].er);
    end

    // Back-to-back A, B, C with valid held high.
    fork
      begin
        int n;
        i_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
          i_left  = abc_l[k];
          i_right = abc_r[k];
          n = 0;
          while (!o_ready && n < 600) begin
            @(negedge i_clk);
            n++;
          end
          @(posedge i_clk);
          @(negedge i_clk);
          if (k == 0) chk("ready_low_after_A", {31'h0, o_ready}, 32'h0);
        end
        i_valid = 1'b0;
      end
      begin
        for (int k = 0; k < 3; k++) begin
          wait_fs();
          chk($sformatf("abc%0d_underrun", k), {31'h0, o_underrun}, 32'h0);
          capture($sformatf("abc%0d", k), abc_l[k], abc_r[k]);
        end
      end
    join

    // Bypass: valid arrives exactly on the frame-start edge with the buffer empty.
    repeat (3) @(negedge i_clk);
    i_left  = 16'hC0DE;
    i_right = 16'h0BEE;
    i_valid = 1'b1;
    @(negedge i_clk);
    i_valid = 1'b0;
    chk("bypass_fs", {31'h0, o_frame_start}, 32'h1);
    chk("bypass_underrun", {31'h0, o_underrun}, 32'h0);
    chk("bypass_ready", {31'h0, o_ready}, 32'h1);
    capture("bypass", 16'hC0DE, 16'h0BEE);

    // Reset mid right slot with a pair waiting in the buffer.
    wait_fs();
    chk("repeat_underrun", {31'h0, o_underrun}, 32'h1);
    offer(16'hDEAD, 16'hBEEF);
    repeat (198) @(negedge i_clk);
    chk("pre_reset_ready", {31'h0, o_ready}, 32'h0);
    i_reset = 1'b1;
    @(negedge i_clk);
    chk("midreset_outputs", {27'h0, o_sck, o_ws, o_sd, o_frame_start, o_underrun}, 32'h0);
    chk("midreset_ready", {31'h0, o_ready}, 32'h0);
    i_reset = 1'b0;
    c0 = cyc;
    #1;
    chk("post_reset_ready", {31'h0, o_ready}, 32'h1);
    offer(16'h0F0F, 16'hF00F);
    wait_fs();
    chk("post_reset_fs_delay", 32'(cyc - c0), 32'd8);
    chk("post_reset_underrun", {31'h0, o_underrun}, 32'h0);
    capture("post_reset", 16'h0F0F, 16'hF00F);
    wait_fs();
    chk("post_reset_repeat_underrun", {31'h0, o_underrun}, 32'h1);
    capture("post_reset_repeat", 16'h0F0F, 16'hF00F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
